// File: rtl/wt_cache_pkg.sv
// Shared L1.5 return-path encodings, FIFO entry layout and byte-order helpers.
package wt_cache_pkg;

  localparam int unsigned L15_TYPE_W = 4;
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned DATA_W     = 2 * WORD_W;

  typedef enum logic [L15_TYPE_W-1:0] {
    LOAD_RET   = 4'b0000,
    IFILL_RET  = 4'b0001,
    INV_RET    = 4'b0011,
    ST_ACK     = 4'b0100,
    ATOMIC_RET = 4'b1110
  } l15_rtntype_e;

  typedef struct packed {
    logic [L15_TYPE_W-1:0] rtype;
    logic [DATA_W-1:0]     data;
  } rtn_entry_t;

  // L1.5 words are big-endian; the caches expect little-endian byte lanes.
  function automatic logic [WORD_W-1:0] bswap64(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic is_fifo_type(input logic [L15_TYPE_W-1:0] t);
    return (t == LOAD_RET) || (t == IFILL_RET) || (t == INV_RET) || (t == ATOMIC_RET);
  endfunction

endpackage

// File: rtl/l15_rtn_fifo.sv
// Small circular buffer holding converted L1.5 returns until a cache consumes them.
module l15_rtn_fifo
  import wt_cache_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rtn_entry_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output rtn_entry_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  rtn_entry_t      mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // Empty head reads as zero so stale storage never leaks onto the outputs.
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/l15_rtn_adapter.sv
// Converts L1.5 return packets into icache/dcache returns and tracks outstanding stores.
module l15_rtn_adapter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned RtnFifoDepth         = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  l15_rtn_val_i,
  output logic                  l15_rtn_ack_o,
  input  logic [L15_TYPE_W-1:0] l15_rtntype_i,
  input  logic [WORD_W-1:0]     l15_data_0_i,
  input  logic [WORD_W-1:0]     l15_data_1_i,
  output logic                  icache_rtn_val_o,
  input  logic                  icache_rtn_ready_i,
  output logic                  dcache_rtn_val_o,
  input  logic                  dcache_rtn_ready_i,
  output logic [L15_TYPE_W-1:0] rtn_type_o,
  output logic [DATA_W-1:0]     rtn_data_o,
  input  logic                  st_issue_i,
  output logic                  st_credit_o,
  output logic [2:0]            st_outstanding_o,
  output logic                  st_idle_o,
  output logic                  err_o
);

  localparam int unsigned   CntW   = 3;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstandingStores);

  logic       fifo_full, fifo_empty;
  logic       accept, push, st_ack, unknown, pop, head_ifill;
  rtn_entry_t push_entry, head;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_err;
  logic            err_q, err_d;

  // Ack depends only on buffer space so the L1.5 side sees no val->ack loop.
  assign l15_rtn_ack_o = ~fifo_full;
  assign accept        = l15_rtn_val_i & l15_rtn_ack_o;
  assign push          = accept & is_fifo_type(l15_rtntype_i);
  assign st_ack        = accept & (l15_rtntype_i == ST_ACK);
  assign unknown       = accept & ~is_fifo_type(l15_rtntype_i) & (l15_rtntype_i != ST_ACK);

  assign push_entry.rtype = l15_rtntype_i;
  assign push_entry.data  = {bswap64(l15_data_1_i), bswap64(l15_data_0_i)};

  l15_rtn_fifo #(
    .Depth(RtnFifoDepth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  // Strict in-order delivery: the head blocks until its own consumer takes it.
  assign head_ifill       = (head.rtype == IFILL_RET);
  assign icache_rtn_val_o = ~fifo_empty & head_ifill;
  assign dcache_rtn_val_o = ~fifo_empty & ~head_ifill;
  assign pop              = (icache_rtn_val_o & icache_rtn_ready_i) |
                            (dcache_rtn_val_o & dcache_rtn_ready_i);
  assign rtn_type_o       = head.rtype;
  assign rtn_data_o       = head.data;

  // Store accounting; an issue and an ack in the same cycle cancel out.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (st_issue_i && !st_ack) begin
      if (cnt_q == MaxCnt) cnt_err = 1'b1;
      else                 cnt_d   = cnt_q + CntW'(1);
    end else if (st_ack && !st_issue_i) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - CntW'(1);
    end
    err_d = err_q | cnt_err | unknown;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign st_outstanding_o = cnt_q;
  assign st_credit_o      = (cnt_q < MaxCnt);
  assign st_idle_o        = (cnt_q == '0);
  assign err_o            = err_q;

endmodule
